demux_4: RTL

//  Registered 1-to-4 demultiplexer with valid/ready handshakes. It is the inverse of the
//  4:1 data selector in the CPU datapath.
//  - Accepts one 16-bit word plus a 2-bit lane select per transfer.
//  - Steers the word into a one-entry holding register on the selected lane (data0..data3).
//  - Each lane drains independently to its consumer.

---
 rtl/demux_4.sv | 129 ++++++++++++
 1 files changed

// File: rtl/demux_4.sv
// Registered 1-to-4 demultiplexer: each lane has a one-entry holding register drained by its own ready.
// Define DEMUX_COUNT_EN to build the per-lane output-transfer counters (cnt0..cnt3), otherwise tied to 0.
module demux_4 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       select,
    output logic [3:0]       valid,
    input  logic [3:0]       ready,
    output logic [WIDTH-1:0] data0,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] data3,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    logic accept_s;

    // Input handshake: target lane must be empty or draining on this same edge.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            in_ready = ~valid[select] | ready[select];
        end
        accept_s = in_valid & in_ready;
    end

    for (genvar g = 0; g < 4; g++) begin : lane_g
        localparam logic [1:0] LANE_ID = 2'(g);

        lane_state_t      state_r;
        lane_state_t      state_nxt_s;
        logic [WIDTH-1:0] data_r;
        logic             load_s;
        logic             drain_s;

        assign load_s   = accept_s & (select == LANE_ID);
        assign drain_s  = (state_r == FULL) & ready[g];
        assign valid[g] = (state_r == FULL);

        // Lane next state; a simultaneous drain and load keeps the lane FULL.
        always_comb begin
            state_nxt_s = state_r;
            case (state_r)
                EMPTY: begin
                    if (load_s) begin
                        state_nxt_s = FULL;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                FULL: begin
                    if (ready[g] & ~load_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: state_nxt_s = EMPTY;
            endcase
        end

        // Lane state and holding register; the word is kept after draining.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r <= EMPTY;
                data_r  <= '0;
            end else begin
                state_r <= state_nxt_s;
                if (load_s) begin
                    data_r <= in_data;
                end else begin
                    data_r <= data_r;
                end
            end
        end

`ifdef DEMUX_COUNT_EN
        logic [CNT_W-1:0] cnt_r;

        // Output-transfer counter, wraps naturally at 2^CNT_W.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r <= '0;
            end else if (drain_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
`else
        logic unused_drain_s;
        assign unused_drain_s = drain_s;
`endif
    end

    assign data0 = lane_g[0].data_r;
    assign data1 = lane_g[1].data_r;
    assign data2 = lane_g[2].data_r;
    assign data3 = lane_g[3].data_r;

`ifdef DEMUX_COUNT_EN
    assign cnt0 = lane_g[0].cnt_r;
    assign cnt1 = lane_g[1].cnt_r;
    assign cnt2 = lane_g[2].cnt_r;
    assign cnt3 = lane_g[3].cnt_r;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
    assign cnt2 = '0;
    assign cnt3 = '0;
`endif

endmodule
